// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// DAC TPL start sequencer: holds the datapath from a sw arm until a synchronised sync_in edge
// plus a link_ready-qualified start delay. Optional ARMED timeout when SYNC_TIMEOUT_EN is defined.
module ad_ip_jesd204_tpl_dac_sync_ctrl #(
  parameter int EXT_SYNC    = 1,
  parameter int DELAY_WIDTH = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   sync_in,
  input  logic                   link_ready,
  input  logic [DELAY_WIDTH-1:0] start_delay,
  input  logic [31:0]            timeout_cycles,
  output logic                   dac_hold,
  output logic                   dac_valid,
  output logic                   armed_status,
  output logic [1:0]             state,
  output logic [CNT_WIDTH-1:0]   sync_count,
  output logic                   timeout_status
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam bit EXT_EN = (EXT_SYNC != 0);

  state_t                 state_q, state_d;
  logic                   sync_m1_q, sync_m2_q, sync_m3_q, sync_edge_q;
  logic                   arm_q, arm_d1_q;
  logic                   arm_edge;
  logic [DELAY_WIDTH-1:0] dly_cnt_q, dly_cnt_d;
  logic [CNT_WIDTH-1:0]   sync_cnt_q, sync_cnt_d;
  logic                   tmo_hit;

  // sync_in is asynchronous: two metastability flops, then a registered edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_m1_q   <= 1'b0;
      sync_m2_q   <= 1'b0;
      sync_m3_q   <= 1'b0;
      sync_edge_q <= 1'b0;
      arm_q       <= 1'b0;
      arm_d1_q    <= 1'b0;
    end else begin
      sync_m1_q   <= sync_in;
      sync_m2_q   <= sync_m1_q;
      sync_m3_q   <= sync_m2_q;
      sync_edge_q <= sync_m2_q & ~sync_m3_q;
      arm_q       <= arm;
      arm_d1_q    <= arm_q;
    end
  end

  assign arm_edge = arm_q & ~arm_d1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dly_cnt_q  <= '0;
      sync_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dly_cnt_q  <= dly_cnt_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dly_cnt_d  = dly_cnt_q;
    sync_cnt_d = sync_cnt_q;
    case (state_q)
      IDLE: begin
        if (arm_edge && EXT_EN) state_d = ARMED;
      end
      ARMED: begin
        // a disarm request beats a sync edge arriving in the same cycle
        if (arm_edge) begin
          state_d = IDLE;
        end else if (sync_edge_q) begin
          if (sync_cnt_q != '1) sync_cnt_d = sync_cnt_q + CNT_WIDTH'(1);
          if (start_delay != '0) begin
            state_d   = DELAY;
            dly_cnt_d = start_delay;
          end else begin
            state_d = RUN;
          end
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      DELAY: begin
        if (arm_edge) begin
          state_d = IDLE;
        end else if (link_ready) begin
          if (dly_cnt_q == DELAY_WIDTH'(1)) state_d = RUN;
          else dly_cnt_d = dly_cnt_q - DELAY_WIDTH'(1);
        end
      end
      RUN: begin
        if (arm_edge) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SYNC_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        tmo_flag_q;

  // counter sits at zero outside ARMED, so every ARMED entry starts from zero
  assign tmo_hit = (state_q == ARMED) && !arm_edge && !sync_edge_q &&
                   (timeout_cycles != 32'd0) && (tmo_cnt_q == timeout_cycles - 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q  <= 32'd0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == ARMED) ? tmo_cnt_q + 32'd1 : 32'd0;
      if (state_q == IDLE && arm_edge && EXT_EN) tmo_flag_q <= 1'b0;
      else if (tmo_hit) tmo_flag_q <= 1'b1;
    end
  end

  assign timeout_status = tmo_flag_q;
`else
  logic unused_tmo;
  assign unused_tmo     = ^timeout_cycles;
  assign tmo_hit        = 1'b0;
  assign timeout_status = 1'b0;
`endif

  assign dac_hold     = (state_q == ARMED) | (state_q == DELAY);
  assign dac_valid    = ~dac_hold;
  assign armed_status = (state_q == ARMED);
  assign state        = state_q;
  assign sync_count   = sync_cnt_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// Scoreboard bench for ad_ip_jesd204_tpl_dac_sync_ctrl; timeout expectations follow SYNC_TIMEOUT_EN.
module tb_ad_ip_jesd204_tpl_dac_sync_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm, sync_in, link_ready;
  logic [15:0] start_delay;
  logic [31:0] timeout_cycles;
  logic        dac_hold, dac_valid, armed_status, timeout_status;
  logic [1:0]  state;
  logic [7:0]  sync_count;
  logic        x_hold, x_valid, x_armed, x_tmo;
  logic [1:0]  x_state;
  logic [7:0]  x_count;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       hold;
    logic [7:0] cnt;
    logic       tmo;
  } exp_t;

  exp_t  sb[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  string tname;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_sync_ctrl dut (
    .clk(clk), .reset(reset), .arm(arm), .sync_in(sync_in), .link_ready(link_ready),
    .start_delay(start_delay), .timeout_cycles(timeout_cycles),
    .dac_hold(dac_hold), .dac_valid(dac_valid), .armed_status(armed_status),
    .state(state), .sync_count(sync_count), .timeout_status(timeout_status)
  );

  ad_ip_jesd204_tpl_dac_sync_ctrl #(.EXT_SYNC(0)) dut_noext (
    .clk(clk), .reset(reset), .arm(arm), .sync_in(sync_in), .link_ready(link_ready),
    .start_delay(start_delay), .timeout_cycles(timeout_cycles),
    .dac_hold(x_hold), .dac_valid(x_valid), .armed_status(x_armed),
    .state(x_state), .sync_count(x_count), .timeout_status(x_tmo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    exp_t e;
    int   base;
    tname = "reset";
    base  = cyc;
    sb.push_back('{base + 2, 2'd0, 1'b0, 8'd0, 1'b0});
    sb.push_back('{base + 4, 2'd0, 1'b0, 8'd0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      if (i == 2) reset = 1'b0;
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if ({state, dac_hold, dac_valid, armed_status, sync_count, timeout_status} !==
            {e.st, e.hold, ~e.hold, (e.st == 2'd1), e.cnt, e.tmo}) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got st=%0d hold=%b vld=%b armed=%b cnt=%0d tmo=%b expected st=%0d hold=%b cnt=%0d tmo=%b",
                   tname, cyc, state, dac_hold, dac_valid, armed_status, sync_count, timeout_status,
                   e.st, e.hold, e.cnt, e.tmo);
        end
      end
    end
    if (sb.size() != 0) begin n_cmp++; n_bad++; $display("FAIL %s unconsumed=%0d required=0", tname, sb.size()); sb.delete(); end
  endtask

  // arm from IDLE, sync pulse, start_delay=4: DELAY one clk after the edge cycle, RUN 5 clk after it
  task automatic test_basic();
    exp_t e;
    int   base;
    tname = "basic";
    base  = cyc;
    start_delay = 16'd4;
    for (int i = 0; i < 15; i++) begin
      if (i == 0) begin
        arm = 1'b1;
        sb.push_back('{base + 1, 2'd0, 1'b0, 8'd0, 1'b0});
        sb.push_back('{base + 2, 2'd1, 1'b1, 8'd0, 1'b0});
      end
      if (i == 4) begin
        sync_in = 1'b1;
        sb.push_back('{base + 7,  2'd1, 1'b1, 8'd0, 1'b0});
        sb.push_back('{base + 8,  2'd2, 1'b1, 8'd1, 1'b0});
        sb.push_back('{base + 11, 2'd2, 1'b1, 8'd1, 1'b0});
        sb.push_back('{base + 12, 2'd3, 1'b0, 8'd1, 1'b0});
        sb.push_back('{base + 14, 2'd3, 1'b0, 8'd1, 1'b0});
      end
      if (i == 6) sync_in = 1'b0;
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if ({state, dac_hold, dac_valid, armed_status, sync_count, timeout_status} !==
            {e.st, e.hold, ~e.hold, (e.st == 2'd1), e.cnt, e.tmo}) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got st=%0d hold=%b vld=%b armed=%b cnt=%0d tmo=%b expected st=%0d hold=%b cnt=%0d tmo=%b",
                   tname, cyc, state, dac_hold, dac_valid, armed_status, sync_count, timeout_status,
                   e.st, e.hold, e.cnt, e.tmo);
        end
      end
    end
    if (sb.size() != 0) begin n_cmp++; n_bad++; $display("FAIL %s unconsumed=%0d required=0", tname, sb.size()); sb.delete(); end
  endtask

  // re-arm from RUN, then a disarm edge lands in the same cycle as the sync edge
  task automatic test_arm_sync_collision();
    exp_t e;
    int   base;
    tname = "collision";
    base  = cyc;
    for (int i = 0; i < 15; i++) begin
      if (i == 0) begin
        arm = 1'b0;
        sb.push_back('{base + 4,  2'd1, 1'b1, 8'd1, 1'b0});
        sb.push_back('{base + 11, 2'd1, 1'b1, 8'd1, 1'b0});
        sb.push_back('{base + 12, 2'd0, 1'b0, 8'd1, 1'b0});
        sb.push_back('{base + 14, 2'd0, 1'b0, 8'd1, 1'b0});
      end
      if (i == 2) arm = 1'b1;
      if (i == 5) arm = 1'b0;
      if (i == 8) sync_in = 1'b1;
      if (i == 10) begin arm = 1'b1; sync_in = 1'b0; end
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if ({state, dac_hold, dac_valid, armed_status, sync_count, timeout_status} !==
            {e.st, e.hold, ~e.hold, (e.st == 2'd1), e.cnt, e.tmo}) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got st=%0d hold=%b vld=%b armed=%b cnt=%0d tmo=%b expected st=%0d hold=%b cnt=%0d tmo=%b",
                   tname, cyc, state, dac_hold, dac_valid, armed_status, sync_count, timeout_status,
                   e.st, e.hold, e.cnt, e.tmo);
        end
      end
    end
    if (sb.size() != 0) begin n_cmp++; n_bad++; $display("FAIL %s unconsumed=%0d required=0", tname, sb.size()); sb.delete(); end
  endtask

  // start_delay=3 with link_ready alternating: release 6 clk after the edge; extra sync and
  // a start_delay change during DELAY have no effect
  task automatic test_link_ready_toggle();
    exp_t e;
    int   base;
    tname = "lr_toggle";
    base  = cyc;
    start_delay = 16'd3;
    for (int i = 0; i < 18; i++) begin
      link_ready = (i % 2 == 1);
      if (i == 0) begin
        arm = 1'b0;
        sb.push_back('{base + 4,  2'd1, 1'b1, 8'd1, 1'b0});
        sb.push_back('{base + 9,  2'd2, 1'b1, 8'd2, 1'b0});
        sb.push_back('{base + 13, 2'd2, 1'b1, 8'd2, 1'b0});
        sb.push_back('{base + 14, 2'd3, 1'b0, 8'd2, 1'b0});
        sb.push_back('{base + 17, 2'd3, 1'b0, 8'd2, 1'b0});
      end
      if (i == 2) arm = 1'b1;
      if (i == 5) sync_in = 1'b1;
      if (i == 7) sync_in = 1'b0;
      if (i == 9) sync_in = 1'b1;
      if (i == 10) begin sync_in = 1'b0; start_delay = 16'd50; end
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if ({state, dac_hold, dac_valid, armed_status, sync_count, timeout_status} !==
            {e.st, e.hold, ~e.hold, (e.st == 2'd1), e.cnt, e.tmo}) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got st=%0d hold=%b vld=%b armed=%b cnt=%0d tmo=%b expected st=%0d hold=%b cnt=%0d tmo=%b",
                   tname, cyc, state, dac_hold, dac_valid, armed_status, sync_count, timeout_status,
                   e.st, e.hold, e.cnt, e.tmo);
        end
      end
    end
    link_ready = 1'b1;
    if (sb.size() != 0) begin n_cmp++; n_bad++; $display("FAIL %s unconsumed=%0d required=0", tname, sb.size()); sb.delete(); end
  endtask

  // start_delay=0: straight ARMED->RUN one clk after the edge cycle
  task automatic test_zero_delay();
    exp_t e;
    int   base;
    tname = "zero_delay";
    base  = cyc;
    start_delay = 16'd0;
    for (int i = 0; i < 11; i++) begin
      if (i == 0) begin
        arm = 1'b0;
        sb.push_back('{base + 4,  2'd1, 1'b1, 8'd2, 1'b0});
        sb.push_back('{base + 8,  2'd1, 1'b1, 8'd2, 1'b0});
        sb.push_back('{base + 9,  2'd3, 1'b0, 8'd3, 1'b0});
        sb.push_back('{base + 10, 2'd3, 1'b0, 8'd3, 1'b0});
      end
      if (i == 2) arm = 1'b1;
      if (i == 5) sync_in = 1'b1;
      if (i == 7) sync_in = 1'b0;
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if ({state, dac_hold, dac_valid, armed_status, sync_count, timeout_status} !==
            {e.st, e.hold, ~e.hold, (e.st == 2'd1), e.cnt, e.tmo}) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got st=%0d hold=%b vld=%b armed=%b cnt=%0d tmo=%b expected st=%0d hold=%b cnt=%0d tmo=%b",
                   tname, cyc, state, dac_hold, dac_valid, armed_status, sync_count, timeout_status,
                   e.st, e.hold, e.cnt, e.tmo);
        end
      end
    end
    if (sb.size() != 0) begin n_cmp++; n_bad++; $display("FAIL %s unconsumed=%0d required=0", tname, sb.size()); sb.delete(); end
  endtask

  // start_delay=100, async reset 40 cycles into DELAY must clear state/hold/count immediately
  task automatic test_reset_mid_delay();
    exp_t e;
    int   base;
    tname = "reset_mid_delay";
    base  = cyc;
    start_delay = 16'd100;
    for (int i = 0; i < 49; i++) begin
      if (i == 0) begin
        arm = 1'b0;
        sb.push_back('{base + 9,  2'd2, 1'b1, 8'd4, 1'b0});
        sb.push_back('{base + 49, 2'd2, 1'b1, 8'd4, 1'b0});
      end
      if (i == 2) arm = 1'b1;
      if (i == 5) sync_in = 1'b1;
      if (i == 7) sync_in = 1'b0;
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if ({state, dac_hold, dac_valid, armed_status, sync_count, timeout_status} !==
            {e.st, e.hold, ~e.hold, (e.st == 2'd1), e.cnt, e.tmo}) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got st=%0d hold=%b vld=%b armed=%b cnt=%0d tmo=%b expected st=%0d hold=%b cnt=%0d tmo=%b",
                   tname, cyc, state, dac_hold, dac_valid, armed_status, sync_count, timeout_status,
                   e.st, e.hold, e.cnt, e.tmo);
        end
      end
    end
    reset = 1'b1;
    sb.push_back('{cyc, 2'd0, 1'b0, 8'd0, 1'b0});
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if ({state, dac_hold, dac_valid, armed_status, sync_count, timeout_status} !==
          {e.st, e.hold, ~e.hold, (e.st == 2'd1), e.cnt, e.tmo}) begin
        n_bad++;
        $display("FAIL %s async got st=%0d hold=%b vld=%b armed=%b cnt=%0d expected st=%0d hold=%b cnt=%0d",
                 tname, state, dac_hold, dac_valid, armed_status, sync_count, e.st, e.hold, e.cnt);
      end
    end
    arm = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  // 300 arm/sync rounds: count saturates at 255; the EXT_SYNC=0 instance never leaves IDLE
  task automatic test_saturation();
    exp_t e;
    int   base;
    int   k;
    tname = "saturation";
    base  = cyc;
    start_delay = 16'd0;
    for (int i = 0; i < 3000; i++) begin
      k = i / 10;
      case (i % 10)
        0: begin
          arm = 1'b0;
          if (k == 0 || k == 1 || (k >= 253 && k <= 256) || k == 299)
            sb.push_back('{base + 10 * k + 9, 2'd3, 1'b0, (k >= 254) ? 8'd255 : 8'(k + 1), 1'b0});
        end
        2: arm = 1'b1;
        5: sync_in = 1'b1;
        7: sync_in = 1'b0;
        default: ;
      endcase
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if ({state, dac_hold, dac_valid, armed_status, sync_count, timeout_status} !==
            {e.st, e.hold, ~e.hold, (e.st == 2'd1), e.cnt, e.tmo}) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got st=%0d hold=%b vld=%b armed=%b cnt=%0d tmo=%b expected st=%0d hold=%b cnt=%0d tmo=%b",
                   tname, cyc, state, dac_hold, dac_valid, armed_status, sync_count, timeout_status,
                   e.st, e.hold, e.cnt, e.tmo);
        end
        n_cmp++;
        if ({x_state, x_hold, x_valid, x_armed, x_count} !== {2'd0, 1'b0, 1'b1, 1'b0, 8'd0}) begin
          n_bad++;
          $display("FAIL noext cyc=%0d got st=%0d hold=%b vld=%b armed=%b cnt=%0d expected st=0 hold=0 vld=1 armed=0 cnt=0",
                   cyc, x_state, x_hold, x_valid, x_armed, x_count);
        end
      end
    end
    if (sb.size() != 0) begin n_cmp++; n_bad++; $display("FAIL %s unconsumed=%0d required=0", tname, sb.size()); sb.delete(); end
  endtask

  // timeout_cycles=10 with no sync, then re-arm with timeout disabled
  task automatic test_timeout();
    exp_t e;
    int   base;
    tname = "timeout";
    base  = cyc;
    for (int i = 0; i < 62; i++) begin
      if (i == 0) begin
        arm = 1'b0;
        timeout_cycles = 32'd10;
`ifdef SYNC_TIMEOUT_EN
        sb.push_back('{base + 4,  2'd1, 1'b1, 8'd255, 1'b0});
        sb.push_back('{base + 13, 2'd1, 1'b1, 8'd255, 1'b0});
        sb.push_back('{base + 14, 2'd0, 1'b0, 8'd255, 1'b1});
        sb.push_back('{base + 19, 2'd0, 1'b0, 8'd255, 1'b1});
        sb.push_back('{base + 20, 2'd1, 1'b1, 8'd255, 1'b0});
        sb.push_back('{base + 60, 2'd1, 1'b1, 8'd255, 1'b0});
`else
        sb.push_back('{base + 4,  2'd1, 1'b1, 8'd255, 1'b0});
        sb.push_back('{base + 14, 2'd1, 1'b1, 8'd255, 1'b0});
        sb.push_back('{base + 19, 2'd1, 1'b1, 8'd255, 1'b0});
        sb.push_back('{base + 20, 2'd0, 1'b0, 8'd255, 1'b0});
        sb.push_back('{base + 60, 2'd0, 1'b0, 8'd255, 1'b0});
`endif
      end
      if (i == 2) arm = 1'b1;
      if (i == 16) arm = 1'b0;
      if (i == 18) begin arm = 1'b1; timeout_cycles = 32'd0; end
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if ({state, dac_hold, dac_valid, armed_status, sync_count, timeout_status} !==
            {e.st, e.hold, ~e.hold, (e.st == 2'd1), e.cnt, e.tmo}) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got st=%0d hold=%b vld=%b armed=%b cnt=%0d tmo=%b expected st=%0d hold=%b cnt=%0d tmo=%b",
                   tname, cyc, state, dac_hold, dac_valid, armed_status, sync_count, timeout_status,
                   e.st, e.hold, e.cnt, e.tmo);
        end
      end
    end
    if (sb.size() != 0) begin n_cmp++; n_bad++; $display("FAIL %s unconsumed=%0d required=0", tname, sb.size()); sb.delete(); end
  endtask

  initial begin
    reset          = 1'b1;
    arm            = 1'b0;
    sync_in        = 1'b0;
    link_ready     = 1'b1;
    start_delay    = 16'd4;
    timeout_cycles = 32'd0;
    test_reset();
    test_basic();
    test_arm_sync_collision();
    test_link_ready_toggle();
    test_zero_delay();
    test_reset_mid_delay();
    test_saturation();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
